alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 6-bit `alu`.
- Adds configurable data width, configurable pipeline depth, valid/ready backpressure, status flags and an opaque tag that travels with each operation.
- Sits between an operand issuer and a result consumer, and is driven directly by `SimClock` instances in simulation.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_core.sv | 72 +++++++
 rtl/alu_pipe.sv | 85 ++++++++
 tb/tb_alu_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag bit positions and flag bundle type for alu_pipe.
// Stage payloads are declared at the use site so that they track WIDTH and TAG_W.
package alu_pkg;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        ADD = 4'd1,
        SUB = 4'd2,
        AND = 4'd3,
        OR  = 4'd4,
        XOR = 4'd5,
        SHL = 4'd6,
        SHR = 4'd7,
        SRA = 4'd8,
        MUL = 4'd9
    } op_e;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_ERR   = 3;

    typedef logic [3:0] flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational op decode, result and {err, ovf, carry, zero} flag generation.
// The multiplier exists only when ALU_MUL_EN is defined; otherwise MUL decodes as illegal.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    localparam logic [WIDTH:0] WIDTH_V = (WIDTH+1)'(WIDTH);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;
    logic           big_shift_s;
    logic           carry_s;
    logic           ovf_s;
    logic           err_s;

    assign sum_s       = {1'b0, a} + {1'b0, b};
    assign diff_s      = {1'b0, a} - {1'b0, b};
    assign big_shift_s = ({1'b0, b} >= WIDTH_V);

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod_s;
    assign prod_s = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

    // Result and raw flags per opcode; bit WIDTH of diff_s is the borrow
    always_comb begin
        result  = '0;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        err_s   = 1'b0;
        case (op)
            NOP: result = '0;
            ADD: begin
                result  = sum_s[WIDTH-1:0];
                carry_s = sum_s[WIDTH];
                ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            SUB: begin
                result  = diff_s[WIDTH-1:0];
                carry_s = diff_s[WIDTH];
                ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            AND: result = a & b;
            OR:  result = a | b;
            XOR: result = a ^ b;
            SHL: result = big_shift_s ? '0 : (a << b);
            SHR: result = big_shift_s ? '0 : (a >> b);
            SRA: result = big_shift_s ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
`ifdef ALU_MUL_EN
            MUL: begin
                result  = prod_s[WIDTH-1:0];
                carry_s = |prod_s[2*WIDTH-1:WIDTH];
            end
`endif
            default: err_s = 1'b1;
        endcase
    end

    assign flags[FLAG_ZERO]  = (result == '0);
    assign flags[FLAG_CARRY] = carry_s;
    assign flags[FLAG_OVF]   = ovf_s;
    assign flags[FLAG_ERR]   = err_s;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready backpressure and a pass-through tag.
// Define ALU_MUL_EN to build the multiplier; otherwise MUL reports an illegal opcode.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  op_e              op_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags,
    output logic [TAG_W-1:0] tag_out,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] result;
        flags_t           flags;
        logic [TAG_W-1:0] tag;
    } stage_t;

    // Entries 0..STAGES-1 are the pipeline stages; entry STAGES is the output register,
    // which gives an accept-to-output latency of exactly STAGES edges.
    stage_t           stage_r [STAGES+1];
    stage_t           load_s;
    logic [WIDTH-1:0] core_result_s;
    flags_t           core_flags_s;
    logic             stall_s;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op     (op_in),
        .a      (a_in),
        .b      (b_in),
        .result (core_result_s),
        .flags  (core_flags_s)
    );

    assign stall_s  = stage_r[STAGES].valid && !out_ready;
    assign in_ready = !stall_s;

    // First-stage payload: the computed op when one is offered, otherwise an all-zero bubble
    always_comb begin
        load_s = '0;
        if (in_valid) begin
            load_s.valid  = 1'b1;
            load_s.result = core_result_s;
            load_s.flags  = core_flags_s;
            load_s.tag    = tag_in;
        end else begin
            load_s.valid = 1'b0;
        end
    end

    // Stage shift register; a stall freezes every entry, bubbles included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else if (!stall_s) begin
            stage_r[0] <= load_s;
            for (int i = 1; i <= STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out       = stage_r[STAGES].result;
    assign flags     = stage_r[STAGES].flags;
    assign tag_out   = stage_r[STAGES].tag;
    assign out_valid = stage_r[STAGES].valid;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=6, STAGES=2, TAG_W=4): directed vectors push
// hand-computed results; a monitor pops and compares each consumed output.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 6;
    localparam int S = 2;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         rst;
    op_e          op_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [T-1:0] tag_in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic [3:0]   flags;
    logic [T-1:0] tag_out;
    logic         out_valid;
    logic         out_ready;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic [T-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    alu_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_in     (op_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .tag_in    (tag_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .flags     (flags),
        .tag_out   (tag_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Present one op and wait (bounded) until it is accepted, then queue its expected result
    task automatic issue(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [T-1:0] tag, input logic [W-1:0] eres, input logic [3:0] eflg);
        int guard;
        exp_t e;
        @(negedge clk); #1;
        op_in = op; a_in = a; b_in = b; tag_in = tag; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            n_vec++; n_miss++;
            $display("FAIL issue_timeout: in_ready=0 after %0d cycles, expected 1", guard);
            in_valid = 1'b0;
        end else begin
            e.res = eres; e.flg = eflg; e.tag = tag;
            exp_q.push_back(e);
            @(posedge clk);
        end
    endtask

    // Called right after an accept edge: out_valid must rise exactly S edges later
    task automatic latency_check(input string name);
        for (int k = 0; k <= S; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #3;
            chk(name, 32'(out_valid), (k == S) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (exp_q.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk); #3;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares each consumed result and checks hold/in_ready while stalled
    initial begin : monitor
        exp_t e;
        exp_t held;
        logic hold_v;
        hold_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (out_valid && !out_ready) begin
                    chk("in_ready_stall", 32'(in_ready), 32'd0);
                    if (hold_v) chk("hold_stable", 32'({out, flags, tag_out}), 32'(held));
                    held   = {out, flags, tag_out};
                    hold_v = 1'b1;
                end else begin
                    hold_v = 1'b0;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_miss++;
                        $display("FAIL unexpected_out: got out=0x%0h tag=%0d, expected no result", out, tag_out);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result{out,flags,tag}", 32'({out, flags, tag_out}), 32'(e));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_in = NOP; a_in = '0; b_in = '0; tag_in = '0;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out",       32'(out),       32'd0);
        chk("rst_flags",     32'(flags),     32'd0);
        chk("rst_tag_out",   32'(tag_out),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ADD wrap with carry and zero, plus latency
        issue(ADD, 6'd63, 6'd1, 4'd5, 6'd0, 4'b0011);
        latency_check("latency_add");

        // Back-to-back mix of ops and boundary cases; flags are {err,ovf,carry,zero}
        issue(SUB, 6'd32,   6'd1,    4'd1,  6'd31,   4'b0100);
        issue(SUB, 6'd1,    6'd2,    4'd2,  6'd63,   4'b0010);
        issue(SRA, 6'h30,   6'd2,    4'd3,  6'h3C,   4'b0000);
        issue(SRA, 6'h30,   6'd9,    4'd4,  6'h3F,   4'b0000);
        issue(SHL, 6'h01,   6'd6,    4'd5,  6'd0,    4'b0001);
        issue(ADD, 6'd31,   6'd1,    4'd6,  6'd32,   4'b0100);
        issue(SHR, 6'h30,   6'd4,    4'd7,  6'd3,    4'b0000);
        issue(AND, 6'h3C,   6'h0F,   4'd8,  6'h0C,   4'b0000);
        issue(OR,  6'h30,   6'h03,   4'd9,  6'h33,   4'b0000);
        issue(XOR, 6'h3F,   6'h3F,   4'd10, 6'd0,    4'b0001);
        issue(NOP, 6'd5,    6'd5,    4'd11, 6'd0,    4'b0001);
        issue(op_e'(4'd15), 6'd3, 6'd4, 4'd12, 6'd0, 4'b1001);
`ifdef ALU_MUL_EN
        issue(MUL, 6'd7,    6'd9,    4'd13, 6'd63,   4'b0000);
        issue(MUL, 6'd8,    6'd8,    4'd14, 6'd0,    4'b0011);
`else
        issue(MUL, 6'd7,    6'd9,    4'd13, 6'd0,    4'b1001);
        issue(MUL, 6'd8,    6'd8,    4'd14, 6'd0,    4'b1001);
`endif
        issue(SHL, 6'd3,    6'd2,    4'd15, 6'd12,   4'b0000);
        issue(SRA, 6'h10,   6'd3,    4'd0,  6'd2,    4'b0000);
        drain();

        // Backpressure: five ADDs, out_ready low for three cycles
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    issue(ADD, 6'(i), 6'd10, 4'(i), 6'(i + 10), 4'b0000);
                end
            end
            begin
                repeat (2) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with one result at the output and two ops in flight
        issue(ADD, 6'd1, 6'd1, 4'd6, 6'd2, 4'b0000);
        issue(ADD, 6'd1, 6'd2, 4'd7, 6'd3, 4'b0000);
        issue(ADD, 6'd1, 6'd3, 4'd8, 6'd4, 4'b0000);
        #1;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_async_drop", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(ADD, 6'd2, 6'd3, 4'd9, 6'd5, 4'b0000);
        latency_check("latency_after_rst");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
